// File: rtl/tdm_pkg.sv
// Package for the TDM receive path.
// Holds the framing FSM state type and a helper that sizes the slot index.
package tdm_pkg;

  typedef enum logic {HUNT, RUN} tdm_state_t;

  // Width of a slot index for n_ch slots. It is never narrower than 1 bit.
  function automatic int unsigned slot_width(input int unsigned n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clr        force the slot index to 0 (highest priority)
//   load1      force the slot index to 1 (slot 0 was just taken)
//   inc        advance to the next slot
//   slot       current slot index
//   last       high when slot == N_CH-1
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned SW   = slot_width(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] slot,
  output logic          last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        slot <= '0;
    else if (clr)   slot <= '0;
    else if (load1) slot <= SW'(1);
    else if (inc)   slot <= slot + 1'b1;
  end

  assign last = (slot == SW'(N_CH - 1));

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer, receive side.
// It locks onto the slot-0 marker (in_sof) and collects the N_CH slot samples
// of each frame into shadow registers. When the last slot arrives, the whole
// frame is committed to out_data at once.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   in_valid    a beat is present this cycle
//   in_sof      the beat is slot 0 (qualified by in_valid)
//   in_data     slot sample
//   out_data    committed frame; channel k at [k*W +: W]
//   out_valid   1-cycle pulse when out_data has just been updated
//   locked      high while the FSM is in RUN
//   sync_err    1-cycle pulse for each framing violation
//   err_cnt     count of framing violations, saturating at 255
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic            out_valid,
  output logic            locked,
  output logic            sync_err,
  output logic [7:0]      err_cnt
);

  localparam int unsigned SW = slot_width(N_CH);

  tdm_state_t                 state;
  logic [N_CH-2:0][W-1:0]     shadow;
  logic [SW-1:0]              slot;
  logic                       last;
  logic                       clr, load1, inc, err;

  // Slot-counter control. An early SOF reloads to 1, just as a normal SOF does.
  // A missing SOF at slot 0 needs no clear, because the counter is already 0.
  always_comb begin
    load1 = 1'b0;
    inc   = 1'b0;
    clr   = 1'b0;
    err   = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        load1 = 1'b1;
        err   = (state == RUN) && (slot != '0);
      end else if (state == RUN) begin
        if (slot == '0) err = 1'b1;
        else if (last)  clr = 1'b1;
        else            inc = 1'b1;
      end
    end
  end

  tdm_slot_ctr #(.N_CH(N_CH), .SW(SW)) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load1 (load1),
    .inc   (inc),
    .slot  (slot),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          shadow[0] <= in_data;
          state     <= RUN;
          locked    <= 1'b1;
        end else if (state == RUN) begin
          if (slot == '0) begin
            state  <= HUNT;
            locked <= 1'b0;
          end else if (last) begin
            out_data  <= {in_data, shadow};
            out_valid <= 1'b1;
          end else begin
            for (int unsigned k = 1; k < N_CH - 1; k++)
              if (slot == SW'(k)) shadow[k] <= in_data;
          end
        end
        if (err) begin
          sync_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = '0;
  logic [31:0] out_data;
  logic        out_valid, locked, sync_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic s, input logic [7:0] d,
                     input logic ev, input logic [31:0] ed, input logic el,
                     input logic ee, input logic [7:0] ec);
    vec_t x;
    x.v = v; x.s = s; x.d = d; x.ev = ev; x.ed = ed; x.el = el; x.ee = ee; x.ec = ec;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic ev, input logic [31:0] ed,
                       input logic el, input logic ee, input logic [7:0] ec);
    checks++;
    if (out_valid !== ev || out_data !== ed || locked !== el ||
        sync_err !== ee || err_cnt !== ec) begin
      failures++;
      $display("FAIL %s got v=%0b d=%h l=%0b e=%0b c=%0d expected v=%0b d=%h l=%0b e=%0b c=%0d",
               name, out_valid, out_data, locked, sync_err, err_cnt, ev, ed, el, ee, ec);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic [7:0] d);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: a single frame
    add(1,1,8'h11, 0,32'h0,1,0,0);
    add(1,0,8'h22, 0,32'h0,1,0,0);
    add(1,0,8'h33, 0,32'h0,1,0,0);
    add(1,0,8'h44, 1,32'h44332211,1,0,0);
    // 2: two back-to-back frames
    add(1,1,8'h01, 0,32'h44332211,1,0,0);
    add(1,0,8'h02, 0,32'h44332211,1,0,0);
    add(1,0,8'h03, 0,32'h44332211,1,0,0);
    add(1,0,8'h04, 1,32'h04030201,1,0,0);
    add(1,1,8'hA1, 0,32'h04030201,1,0,0);
    add(1,0,8'hA2, 0,32'h04030201,1,0,0);
    add(1,0,8'hA3, 0,32'h04030201,1,0,0);
    add(1,0,8'hA4, 1,32'hA4A3A2A1,1,0,0);
    // 3: gaps, with junk on idle cycles that must be ignored
    add(1,1,8'h11, 0,32'hA4A3A2A1,1,0,0);
    add(0,1,8'hFF, 0,32'hA4A3A2A1,1,0,0);
    add(0,0,8'hEE, 0,32'hA4A3A2A1,1,0,0);
    add(1,0,8'h22, 0,32'hA4A3A2A1,1,0,0);
    add(0,1,8'hFF, 0,32'hA4A3A2A1,1,0,0);
    add(0,0,8'h00, 0,32'hA4A3A2A1,1,0,0);
    add(1,0,8'h33, 0,32'hA4A3A2A1,1,0,0);
    add(0,0,8'hDD, 0,32'hA4A3A2A1,1,0,0);
    add(0,1,8'hCC, 0,32'hA4A3A2A1,1,0,0);
    add(1,0,8'h44, 1,32'h44332211,1,0,0);
    // 4: early SOF after 2 slots
    add(1,1,8'h99, 0,32'h44332211,1,0,0);
    add(1,0,8'h98, 0,32'h44332211,1,0,0);
    add(1,1,8'h55, 0,32'h44332211,1,1,1);
    add(1,0,8'h66, 0,32'h44332211,1,0,1);
    add(1,0,8'h77, 0,32'h44332211,1,0,1);
    add(1,0,8'h88, 1,32'h88776655,1,0,1);
    add(0,0,8'h00, 0,32'h88776655,1,0,1);
    // 5: missing SOF at slot 0, then silent drops until relock
    add(1,0,8'h12, 0,32'h88776655,0,1,2);
    add(1,0,8'h13, 0,32'h88776655,0,0,2);
    add(1,0,8'h14, 0,32'h88776655,0,0,2);
    add(1,1,8'h21, 0,32'h88776655,1,0,2);
    add(1,0,8'h22, 0,32'h88776655,1,0,2);
    add(1,0,8'h23, 0,32'h88776655,1,0,2);
    add(1,0,8'h24, 1,32'h24232221,1,0,2);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset", 0, 32'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      beat(vecs[i].v, vecs[i].s, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].ee, vecs[i].ec);
    end

    // 6: saturation. The first SOF at slot 0 is legal; each later SOF lands
    // at slot 1 and counts as an error.
    beat(1, 1, 8'h30);
    check("sat_first", 0, 32'h24232221, 1, 0, 2);
    for (int i = 1; i <= 300; i++) begin
      beat(1, 1, 8'h30);
      if (i == 253)
        check("sat_reach", 0, 32'h24232221, 1, 1, 8'd255);
    end
    check("sat_hold", 0, 32'h24232221, 1, 1, 8'd255);
    beat(1, 0, 8'h31);
    check("sat_quiet", 0, 32'h24232221, 1, 0, 8'd255);

    // Asynchronous reset in the middle of a frame
    #2 rst = 1'b1;
    #1;
    check("async_rst", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    beat(1, 0, 8'h32);
    check("post_rst_drop", 0, 32'h0, 0, 0, 0);
    beat(1, 0, 8'h33);
    check("post_rst_drop2", 0, 32'h0, 0, 0, 0);
    beat(0, 0, 8'h00);
    check("post_rst_idle", 0, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
